// File: rtl/reg_file_arb.sv
// Round-robin arbiter in front of a single-port register file: one access per
// cycle with a registered grant, read data returned to the grantee one cycle later.
`timescale 1ns/1ps
module reg_file_arb #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 3,
    localparam int AW     = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     busy,
    output logic                     rf_wr_en,
    output logic [AW-1:0]            rf_addr,
    output logic [WIDTH-1:0]         rf_wr_data,
    input  logic [WIDTH-1:0]         rf_rd_data
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               rf_wr_en_q, rf_wr_en_d;
    logic [AW-1:0]      rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;

    logic [NUM_REQ-1:0] cand;
    logic               win;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        pos;

    always_comb begin
        // The current grantee still shows req during its gnt cycle.
        cand    = (state_q == ACCESS) ? (req & ~gnt_q) : req;
        win     = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr_q} + (PW+1)'(i);
            if (pos >= (PW+1)'(NUM_REQ))
                pos = pos - (PW+1)'(NUM_REQ);
            if (!win && cand[pos[PW-1:0]]) begin
                win     = 1'b1;
                win_idx = pos[PW-1:0];
            end
        end

        state_d      = win ? ACCESS : IDLE;
        gnt_d        = '0;
        rf_wr_en_d   = 1'b0;
        rf_addr_d    = '0;
        rf_wr_data_d = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win && win_idx == PW'(j)) begin
                gnt_d[j]     = 1'b1;
                rf_wr_en_d   = req_we[j];
                rf_addr_d    = req_addr[j*AW +: AW];
                rf_wr_data_d = req_wdata[j*WIDTH +: WIDTH];
            end
        end

        ptr_d = ptr_q;
        if (win)
            ptr_d = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (state_q == ACCESS && !rf_wr_en_q) begin
            rvalid_d = gnt_q;
            rdata_d  = rf_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q == ACCESS);
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
endmodule

// File: tb/tb_reg_file_arb.sv
// Directed bench for reg_file_arb: a 2-requester instance with a register-file
// model and a 4-requester instance for round-robin fairness.
`timescale 1ns/1ps
module tb_reg_file_arb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-requester instance, WIDTH = 3, AW = 2
    logic [1:0] req2, we2, gnt2, rvalid2;
    logic [3:0] addr2;
    logic [5:0] wdata2;
    logic [2:0] rdata2, rfwd2, rfrd2;
    logic [1:0] rfaddr2;
    logic       busy2, rfwe2;
    logic [2:0] mem [0:3] = '{default: 3'b000};

    always @(posedge clk) if (rfwe2) mem[rfaddr2] <= rfwd2;
    assign rfrd2 = rfwe2 ? 3'b000 : mem[rfaddr2];

    reg_file_arb #(.NUM_REQ(2), .WIDTH(3)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_we(we2), .req_addr(addr2),
        .req_wdata(wdata2), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
        .busy(busy2), .rf_wr_en(rfwe2), .rf_addr(rfaddr2), .rf_wr_data(rfwd2),
        .rf_rd_data(rfrd2)
    );

    // Four-requester instance; its register file returns {1, addr}
    logic [3:0]  req4, we4, gnt4, rvalid4;
    logic [7:0]  addr4;
    logic [11:0] wdata4;
    logic [2:0]  rdata4, rfwd4, rfrd4;
    logic [1:0]  rfaddr4;
    logic        busy4, rfwe4;
    assign rfrd4 = rfwe4 ? 3'b000 : {1'b1, rfaddr4};

    reg_file_arb #(.NUM_REQ(4), .WIDTH(3)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .req_we(we4), .req_addr(addr4),
        .req_wdata(wdata4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
        .busy(busy4), .rf_wr_en(rfwe4), .rf_addr(rfaddr4), .rf_wr_data(rfwd4),
        .rf_rd_data(rfrd4)
    );

    task automatic test_reset;
        req2 = 2'b11; we2 = 2'b00; addr2 = '0;
        repeat (2) @(negedge clk);
        $display("txn reset held with req=11");
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt2); end
        checks++; if (rfwe2 !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", rfwe2); end
        checks++; if (rvalid2 !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy2); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset released, first grant");
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL reset_first_gnt: got %b expected 01", gnt2); end
        req2 = 2'b00;
        @(negedge clk);
        checks++; if (rvalid2 !== 2'b01) begin errors++; $display("FAIL reset_first_rvalid: got %b expected 01", rvalid2); end
        @(negedge clk);
    endtask

    task automatic test_write_read;
        req2 = 2'b10; we2 = 2'b10; addr2 = {2'd2, 2'd0}; wdata2 = {3'b101, 3'b000};
        @(negedge clk);
        $display("txn req1 write addr2=101");
        checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b expected 10", gnt2); end
        checks++; if ({rfwe2, rfaddr2, rfwd2} !== {1'b1, 2'd2, 3'b101}) begin errors++; $display("FAIL wr_rf_bus: got %b expected 110101", {rfwe2, rfaddr2, rfwd2}); end
        req2 = 2'b00;
        @(negedge clk);
        checks++; if (mem[2] !== 3'b101) begin errors++; $display("FAIL wr_mem: got %b expected 101", mem[2]); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL wr_idle_busy: got %b expected 0", busy2); end
        req2 = 2'b10; we2 = 2'b00;
        @(negedge clk);
        $display("txn req1 read addr2");
        checks++; if ({gnt2, rfwe2} !== 3'b100) begin errors++; $display("FAIL rd_gnt: got %b expected 100", {gnt2, rfwe2}); end
        req2 = 2'b00;
        @(negedge clk);
        checks++; if (rvalid2 !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b expected 10", rvalid2); end
        checks++; if (rdata2 !== 3'b101) begin errors++; $display("FAIL rd_rdata: got %b expected 101", rdata2); end
        @(negedge clk);
    endtask

    task automatic test_overlap;
        req2 = 2'b10; we2 = 2'b10; addr2 = {2'd1, 2'd0}; wdata2 = {3'b011, 3'b000};
        @(negedge clk);
        req2 = 2'b00;
        @(negedge clk);
        $display("txn preload addr1=011, then req0 read addr1 with req1 write addr3");
        req2 = 2'b11; we2 = 2'b10; addr2 = {2'd3, 2'd1}; wdata2 = {3'b110, 3'b000};
        @(negedge clk);
        checks++; if ({gnt2, rfwe2} !== 3'b010) begin errors++; $display("FAIL ovl_gnt0: got %b expected 010", {gnt2, rfwe2}); end
        req2 = 2'b10;
        @(negedge clk);
        checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL ovl_gnt1: got %b expected 10", gnt2); end
        checks++; if (rvalid2 !== 2'b01) begin errors++; $display("FAIL ovl_rvalid: got %b expected 01", rvalid2); end
        checks++; if (rdata2 !== 3'b011) begin errors++; $display("FAIL ovl_rdata: got %b expected 011", rdata2); end
        req2 = 2'b00;
        @(negedge clk);
        checks++; if (rvalid2 !== 2'b00) begin errors++; $display("FAIL ovl_wr_no_rvalid: got %b expected 00", rvalid2); end
        checks++; if (rdata2 !== 3'b011) begin errors++; $display("FAIL ovl_rdata_hold: got %b expected 011", rdata2); end
        checks++; if (mem[3] !== 3'b110) begin errors++; $display("FAIL ovl_mem3: got %b expected 110", mem[3]); end
        @(negedge clk);
    endtask

    task automatic test_contention;
        logic [1:0] exp;
        req2 = 2'b11; we2 = 2'b00; addr2 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            $display("txn contention cycle %0d gnt=%b", k, gnt2);
            checks++; if ({gnt2, busy2} !== {exp, 1'b1}) begin errors++; $display("FAIL contention_gnt%0d: got %b expected %b", k, {gnt2, busy2}, {exp, 1'b1}); end
        end
        req2 = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_rate;
        logic [1:0] exp;
        req2 = 2'b01; we2 = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = (k % 2 == 0) ? 2'b01 : 2'b00;
            $display("txn single requester cycle %0d gnt=%b", k, gnt2);
            checks++; if (gnt2 !== exp) begin errors++; $display("FAIL single_gnt%0d: got %b expected %b", k, gnt2, exp); end
        end
        req2 = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        req2 = 2'b01; we2 = 2'b01; addr2 = {2'd0, 2'd0}; wdata2 = {3'b000, 3'b111};
        @(negedge clk);
        $display("txn req0 write addr0=111, reset during gnt");
        checks++; if ({gnt2, rfwe2} !== 3'b011) begin errors++; $display("FAIL mid_gnt: got %b expected 011", {gnt2, rfwe2}); end
        req2 = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rfwe2, gnt2, busy2} !== 4'b0000) begin errors++; $display("FAIL mid_async_clear: got %b expected 0000", {rfwe2, gnt2, busy2}); end
        @(negedge clk);
        checks++; if (mem[0] !== 3'b000) begin errors++; $display("FAIL mid_mem_kept: got %b expected 000", mem[0]); end
        rst_n = 1'b1; req2 = 2'b11; we2 = 2'b00;
        @(negedge clk);
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL mid_ptr_reset: got %b expected 01", gnt2); end
        req2 = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness;
        logic [3:0] exp;
        logic [3:0] prev;
        req4 = 4'b1111; we4 = 4'b0000; addr4 = {2'd3, 2'd2, 2'd1, 2'd0};
        prev = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp = 4'b0001 << (k % 4);
            $display("txn fairness cycle %0d gnt=%b", k, gnt4);
            checks++; if (gnt4 !== exp) begin errors++; $display("FAIL fair_gnt%0d: got %b expected %b", k, gnt4, exp); end
            if (k > 0) begin
                checks++; if (rvalid4 !== prev) begin errors++; $display("FAIL fair_rvalid%0d: got %b expected %b", k, rvalid4, prev); end
                checks++; if (rdata4 !== {1'b1, 2'((k - 1) % 4)}) begin errors++; $display("FAIL fair_rdata%0d: got %b expected %b", k, rdata4, {1'b1, 2'((k - 1) % 4)}); end
            end
            prev = exp;
        end
        req4 = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
        req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
        test_reset;
        test_write_read;
        test_overlap;
        test_contention;
        test_single_rate;
        test_reset_mid_access;
        test_fairness;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
